deserializer_16_frame_align: RTL and testbench
==============================================

# deserializer_16_frame_align

Receive-side counterpart of the 16-to-1 serializer. Accepts one MSB-first bit per qualified clock, hunts for a 16-bit sync word at any bit offset, then flywheels on the resulting frame alignment. Emits 16-bit payload words with single-cycle valid strobes, plus lock status. Sits directly downstream of the serializer in loopback and link paths.

## Interface
- SYNC_WORD, 16'hA5C3: frame sync pattern; occupies word 0 of every frame.
- FRAME_WORDS, 8: words per frame, including the sync word; legal range is 2 or more.
- LOCK_MISS_MAX, 4: consecutive bad sync words that drop lock; legal range is 1 or more.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial data, MSB of each word first.
- bit_valid  in  1  bit_in is accepted on this edge; when low, all state holds.
- word_out  out  16  last completed payload word.
- word_valid  out  1  one-cycle strobe; word_out is new.
- word_first  out  1  qualifies word_valid; high for frame word 1.
- locked  out  1  frame alignment established.
- sync_seen  out  1  one-cycle pulse on each matching sync word.

## Operation
- Shift register sr[15:0]: on each accepted bit, sr <= {sr[14:0], bit_in}. Define cand = {sr[14:0], bit_in}.
- fill_cnt is 0..16 and saturates at 16. It increments per accepted bit and prevents matches on reset contents.
- State HUNT (reset state, locked = 0):
  - Compare cand to SYNC_WORD on every accepted bit once fill_cnt >= 15, i.e. on the 16th bit onward.
  - On a match: go to LOCKED, set bit_cnt = 0, word_idx = 1, miss_cnt = 0, and pulse sync_seen.
  - No word_valid is produced in HUNT.
- State LOCKED (locked = 1):
  - bit_cnt counts 0..15 per accepted bit. On the bit with bit_cnt == 15, cand is a complete word.
  - Payload word (word_idx != 0): word_out <= cand and word_valid pulses. word_first = (word_idx == 1).
  - Sync word (word_idx == 0): never output.
    - On a match, pulse sync_seen and clear miss_cnt.
    - On a mismatch, miss_cnt increments. If it reaches LOCK_MISS_MAX, go to HUNT with locked = 0. Otherwise stay aligned (flywheel).
  - word_idx wraps from FRAME_WORDS-1 to 0.
- On a lock drop, sr and fill_cnt (already 16) are kept. The hunt resumes on the next accepted bit, so a sync candidate may then match at a new offset.
- Counter widths: bit_cnt is 4 bits; word_idx is $clog2(FRAME_WORDS); miss_cnt is $clog2(LOCK_MISS_MAX+1).
- Reset values: word_out = 0, word_valid = 0, word_first = 0, locked = 0, sync_seen = 0, sr = 0, fill_cnt = 0, all counters = 0, state = HUNT.

## Timing
- All outputs are registered.
- word_valid, word_first and sync_seen go high for exactly one cycle, after the edge that accepts the word's last bit (LSB). They are low on every other cycle, including cycles where bit_valid = 0.
- locked rises after the edge that accepts the LSB of the first matching sync word. It falls after the edge that accepts the LSB of the LOCK_MISS_MAX-th consecutive bad sync word.
- Latency: a payload LSB accepted at edge N means word_out and word_valid are valid in cycle N+1.
- With continuous bit_valid, word_valid strobes are 16 cycles apart. The gap spans 32 cycles across a sync word.
- A bit_valid gap stretches timing but never corrupts alignment or content.
- Asserting rst mid-word or mid-frame clears all outputs immediately, without a clock. After release, at least 16 accepted bits are needed before any match.
- The block has no backpressure. The consumer must take word_out in the cycle word_valid is high.
- Toward the upstream serializer, the serializer's load/ready pacing only affects bit_valid timing. The bitstream must be gapless from the serializer's perspective, or bit_valid must be low on the idle cycles.

## Test plan
- Reset, then continuous stream: 16'h1234, SYNC_WORD, payload 16'h0001..16'h0007.
  - Response: locked rises after the sync LSB. Seven word_valid strobes 16 cycles apart, values 0x0001..0x0007, word_first only with 0x0001. One sync_seen pulse.
- Five junk bits 1,0,1,1,0 before SYNC_WORD, then two frames.
  - Response: correct bit-offset alignment, 14 payload words exact, two sync_seen pulses.
- Locked, frame-2 sync replaced by 16'hFFFF, LOCK_MISS_MAX = 4.
  - Response: locked stays 1, no sync_seen for frame 2, frame-2 payload still emitted, miss_cnt returns to 0 on frame-3 sync.
- Four consecutive bad syncs, then a valid frame.
  - Response: locked falls after the 4th bad sync LSB. No word_valid until relock. Relock on the next good sync.
- bit_valid pseudo-random at 50% duty over three frames.
  - Response: word_out sequence identical to the continuous case. No strobe on a bit_valid-low edge.
- Assert rst asynchronously mid-payload, then release and resend full frames with SYNC_WORD = 16'h0000.
  - Response: outputs zero immediately on rst. No match within the first 15 accepted bits. Locks on the real sync word.

Source files
------------

// File: rtl/deserializer_16_frame_align.sv
// ---------------------------------------------------------------------------
// deserializer_16_frame_align
//
// Receive side of the 16-to-1 serial link. Takes one MSB-first bit per
// qualified clock, hunts for SYNC_WORD at any bit offset, then flywheels on
// that frame alignment. It emits the payload words of each frame and reports
// lock status. Word 0 of every frame is the sync word and is never emitted.
//
// Parameters
//   SYNC_WORD      frame sync pattern (word 0 of every frame)
//   FRAME_WORDS    words per frame including the sync word (>= 2)
//   LOCK_MISS_MAX  consecutive bad sync words that drop lock (>= 1)
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_i          asynchronous active-high reset
//   bit_in_i       serial data, MSB of each word first
//   bit_valid_i    bit_in_i is accepted on this edge; otherwise all state holds
//   word_out_o     last completed payload word
//   word_valid_o   one-cycle strobe, word_out_o is new
//   word_first_o   qualifies word_valid_o, high for frame word 1
//   locked_o       frame alignment established
//   sync_seen_o    one-cycle pulse on each matching sync word
// ---------------------------------------------------------------------------
module deserializer_16_frame_align #(
  parameter logic [15:0] SYNC_WORD     = 16'hA5C3,
  parameter int unsigned FRAME_WORDS   = 8,
  parameter int unsigned LOCK_MISS_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bit_in_i,
  input  logic        bit_valid_i,
  output logic [15:0] word_out_o,
  output logic        word_valid_o,
  output logic        word_first_o,
  output logic        locked_o,
  output logic        sync_seen_o
);

  localparam int unsigned IDX_W  = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned MISS_W = (LOCK_MISS_MAX > 1) ? $clog2(LOCK_MISS_MAX + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0]  FIRST_IDX = IDX_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOCK_MISS_MAX - 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        sr_q, sr_d;
  logic [4:0]         fill_q, fill_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [15:0]        word_out_q, word_out_d;
  logic               word_valid_q, word_valid_d;
  logic               word_first_q, word_first_d;
  logic               sync_seen_q, sync_seen_d;

  // The candidate word includes the bit being accepted this edge, so a match
  // is recognised on the same edge that shifts in the LSB.
  logic [15:0] cand;
  logic        cand_match;

  assign cand       = {sr_q[14:0], bit_in_i};
  assign cand_match = (cand == SYNC_WORD);

  // State registers; the async reset clears every output without a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      miss_q       <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      word_first_q <= 1'b0;
      sync_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      miss_q       <= miss_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      word_first_q <= word_first_d;
      sync_seen_q  <= sync_seen_d;
    end
  end

  // Next-state logic. Strobes default low so they last exactly one cycle and
  // stay low on cycles without an accepted bit.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    miss_d       = miss_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    word_first_d = 1'b0;
    sync_seen_d  = 1'b0;

    if (bit_valid_i) begin
      sr_d = cand;
      if (fill_q != 5'd16) begin
        fill_d = fill_q + 5'd1;
      end

      unique case (state_q)
        HUNT: begin
          // fill_q >= 15 means this bit completes the first 16 received
          // since reset, so reset contents never take part in a match.
          if ((fill_q >= 5'd15) && cand_match) begin
            state_d     = LOCKED;
            bit_cnt_d   = '0;
            word_idx_d  = FIRST_IDX;
            miss_d      = '0;
            sync_seen_d = 1'b1;
          end
        end

        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
            if (word_idx_q != '0) begin
              word_out_d   = cand;
              word_valid_d = 1'b1;
              word_first_d = (word_idx_q == FIRST_IDX);
            end else if (cand_match) begin
              sync_seen_d = 1'b1;
              miss_d      = '0;
            end else if (miss_q == MISS_LAST) begin
              // sr and fill are kept, so hunting resumes on the next bit.
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign word_out_o   = word_out_q;
  assign word_valid_o = word_valid_q;
  assign word_first_o = word_first_q;
  assign sync_seen_o  = sync_seen_q;
  assign locked_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_deserializer_16_frame_align.sv
// ---------------------------------------------------------------------------
// tb_deserializer_16_frame_align
//
// Drives two deserializers with the same bitstream: one with sync word
// 16'hA5C3 and one with sync word 16'h0000 (the latter shows that reset
// contents cannot produce an early match). Expected outputs come from a
// bitstream-level model that searches the recorded stream for sync windows
// and walks frame boundaries arithmetically.
// ---------------------------------------------------------------------------
module tb_deserializer_16_frame_align;

  localparam logic [15:0] SYNC_A = 16'hA5C3;
  localparam logic [15:0] SYNC_B = 16'h0000;
  localparam int FW   = 8;
  localparam int MM   = 4;
  localparam int MAXB = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bitIn = 1'b0;
  logic        bitValid = 1'b0;
  logic [15:0] wordO [2];
  logic        validO [2];
  logic        firstO [2];
  logic        lockedO [2];
  logic        syncO [2];

  int errors = 0;
  int checks = 0;

  // Recorded stream and per-accepted-bit expectations for each instance
  bit          streamQ [$];
  bit          mV [2][MAXB];
  bit          mF [2][MAXB];
  bit          mS [2][MAXB];
  bit          mL [2][MAXB];
  logic [15:0] mW [2][MAXB];

  int          kIdx = 0;
  bit          lastLk [2];
  logic [15:0] lastWord [2];
  bit          obsLk [2];

  // Observation logs used by the hand-computed expectations
  logic [15:0] wordsA [$];
  logic [15:0] wordsB [$];
  bit          firstA [$];
  int          seenAtA [$];
  int          risesA [$];
  int          fallsA [$];
  int          risesB [$];
  int          syncCount [2];

  always #5 clk = ~clk;

  deserializer_16_frame_align #(
    .SYNC_WORD(SYNC_A), .FRAME_WORDS(FW), .LOCK_MISS_MAX(MM)
  ) u_dutA (
    .clk_i(clk), .rst_i(rst), .bit_in_i(bitIn), .bit_valid_i(bitValid),
    .word_out_o(wordO[0]), .word_valid_o(validO[0]), .word_first_o(firstO[0]),
    .locked_o(lockedO[0]), .sync_seen_o(syncO[0])
  );

  deserializer_16_frame_align #(
    .SYNC_WORD(SYNC_B), .FRAME_WORDS(FW), .LOCK_MISS_MAX(MM)
  ) u_dutB (
    .clk_i(clk), .rst_i(rst), .bit_in_i(bitIn), .bit_valid_i(bitValid),
    .word_out_o(wordO[1]), .word_valid_o(validO[1]), .word_first_o(firstO[1]),
    .locked_o(lockedO[1]), .sync_seen_o(syncO[1])
  );

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] win(input int k);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = streamQ[k-15+i];
    return w;
  endfunction

  // Model: find the first sync window at or after the hunt start, then visit
  // every 16th bit after it as a word end; word number mod FW picks payload
  // versus sync slot. A run of MM bad syncs restarts the hunt one bit later.
  task automatic buildModel(input int d, input logic [15:0] sw);
    int n;
    int p;
    int found;
    int s;
    int j;
    int e;
    int wi;
    int misses;
    n = streamQ.size();
    p = 0;
    for (int i = 0; i < MAXB; i++) begin
      mV[d][i] = 0; mF[d][i] = 0; mS[d][i] = 0; mL[d][i] = 0; mW[d][i] = '0;
    end
    while (p < n) begin
      found = -1;
      for (int k = (p < 15) ? 15 : p; k < n; k++) begin
        if (win(k) == sw) begin
          found = k;
          break;
        end
      end
      if (found < 0) break;
      mS[d][found] = 1;
      for (int i = found; i < n; i++) mL[d][i] = 1;
      s = found;
      misses = 0;
      j = 1;
      p = n;
      while (s + 16 * j < n) begin
        e = s + 16 * j;
        wi = j % FW;
        if (wi != 0) begin
          mV[d][e] = 1;
          mW[d][e] = win(e);
          mF[d][e] = (wi == 1);
        end else if (win(e) == sw) begin
          mS[d][e] = 1;
          misses = 0;
        end else begin
          misses++;
          if (misses == MM) begin
            for (int i = e; i < n; i++) mL[d][i] = 0;
            p = e + 1;
            break;
          end
        end
        j++;
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model
  task automatic checkOutput(input bit acc);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        checkWord($sformatf("rst word_out dut%0d", d), wordO[d], 16'h0000);
        checkBit($sformatf("rst word_valid dut%0d", d), validO[d], 1'b0);
        checkBit($sformatf("rst word_first dut%0d", d), firstO[d], 1'b0);
        checkBit($sformatf("rst locked dut%0d", d), lockedO[d], 1'b0);
        checkBit($sformatf("rst sync_seen dut%0d", d), syncO[d], 1'b0);
      end else begin
        if (acc) begin
          if (mV[d][kIdx]) lastWord[d] = mW[d][kIdx];
          lastLk[d] = mL[d][kIdx];
          checkBit($sformatf("word_valid dut%0d bit%0d", d, kIdx), validO[d], mV[d][kIdx]);
          checkBit($sformatf("word_first dut%0d bit%0d", d, kIdx), firstO[d], mF[d][kIdx]);
          checkBit($sformatf("sync_seen dut%0d bit%0d", d, kIdx), syncO[d], mS[d][kIdx]);
        end else begin
          checkBit($sformatf("idle word_valid dut%0d bit%0d", d, kIdx), validO[d], 1'b0);
          checkBit($sformatf("idle word_first dut%0d bit%0d", d, kIdx), firstO[d], 1'b0);
          checkBit($sformatf("idle sync_seen dut%0d bit%0d", d, kIdx), syncO[d], 1'b0);
        end
        checkBit($sformatf("locked dut%0d bit%0d", d, kIdx), lockedO[d], lastLk[d]);
        checkWord($sformatf("word_out dut%0d bit%0d", d, kIdx), wordO[d], lastWord[d]);
        if (syncO[d]) syncCount[d]++;
        if (d == 0) begin
          if (validO[0]) begin
            wordsA.push_back(wordO[0]);
            firstA.push_back(firstO[0]);
            seenAtA.push_back(kIdx);
          end
          if (lockedO[0] && !obsLk[0]) risesA.push_back(kIdx);
          if (!lockedO[0] && obsLk[0]) fallsA.push_back(kIdx);
        end else begin
          if (validO[1]) wordsB.push_back(wordO[1]);
          if (lockedO[1] && !obsLk[1]) risesB.push_back(kIdx);
        end
        obsLk[d] = lockedO[d];
      end
    end
    if (rst) begin
      kIdx = 0;
      for (int d = 0; d < 2; d++) begin
        lastLk[d] = 0; lastWord[d] = '0; obsLk[d] = 0;
      end
    end else if (acc) begin
      kIdx++;
    end
  endtask

  task automatic applyStimulus(input logic b, input logic v);
    bit acc;
    bitIn = b;
    bitValid = v;
    @(posedge clk);
    acc = v && !rst;
    #1;
    checkOutput(acc);
  endtask

  task automatic clearLogs();
    wordsA.delete(); wordsB.delete(); firstA.delete(); seenAtA.delete();
    risesA.delete(); fallsA.delete(); risesB.delete();
    syncCount[0] = 0;
    syncCount[1] = 0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bitValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(1'b0);
    rst = 1'b0;
    clearLogs();
    streamQ.delete();
  endtask

  task automatic pushWord(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) streamQ.push_back(w[i]);
  endtask

  task automatic pushFrame(input logic [15:0] sw, input logic [15:0] base);
    pushWord(sw);
    for (int i = 1; i < FW; i++) pushWord(base + 16'(i));
  endtask

  task automatic buildBoth();
    buildModel(0, SYNC_A);
    buildModel(1, SYNC_B);
  endtask

  // Sends stream bits [from, to); with gaps, idle cycles carry random data
  task automatic runRange(input int from, input int to, input bit gaps);
    for (int k = from; k < to; k++) begin
      if (gaps) begin
        for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
          applyStimulus(1'($urandom_range(0, 1)), 1'b0);
        end
      end
      applyStimulus(streamQ[k], 1'b1);
    end
    for (int g = 0; g < 4; g++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    $display("[TB] start");

    // Leading word then sync and seven payload words
    doReset();
    pushWord(16'h1234);
    pushFrame(SYNC_A, 16'h0000);
    buildBoth();
    runRange(0, streamQ.size(), 1'b0);
    checkInt("seg1 word count", wordsA.size(), 7);
    for (int i = 0; i < wordsA.size() && i < 7; i++) begin
      checkWord($sformatf("seg1 word %0d", i), wordsA[i], 16'(i + 1));
      checkBit($sformatf("seg1 first %0d", i), firstA[i], i == 0);
      if (i > 0) checkInt($sformatf("seg1 spacing %0d", i), seenAtA[i] - seenAtA[i-1], 16);
    end
    if (seenAtA.size() > 0) checkInt("seg1 first word bit", seenAtA[0], 47);
    checkInt("seg1 sync count", syncCount[0], 1);
    checkInt("seg1 lock rises", risesA.size(), 1);
    if (risesA.size() > 0) checkInt("seg1 lock bit", risesA[0], 31);

    // Five junk bits, then two frames
    doReset();
    streamQ.push_back(1); streamQ.push_back(0); streamQ.push_back(1);
    streamQ.push_back(1); streamQ.push_back(0);
    pushFrame(SYNC_A, 16'h1000);
    pushFrame(SYNC_A, 16'h2000);
    buildBoth();
    runRange(0, streamQ.size(), 1'b0);
    checkInt("seg2 word count", wordsA.size(), 14);
    for (int i = 0; i < wordsA.size() && i < 14; i++) begin
      checkWord($sformatf("seg2 word %0d", i),
                wordsA[i], ((i < 7) ? 16'h1000 : 16'h2000) + 16'((i % 7) + 1));
    end
    checkInt("seg2 sync count", syncCount[0], 2);
    if (risesA.size() > 0) checkInt("seg2 lock bit", risesA[0], 20);

    // Isolated bad sync, good sync, then three bad syncs: miss count must
    // have cleared, so lock is never lost
    doReset();
    pushFrame(SYNC_A, 16'h0100);
    pushFrame(16'hFFFF, 16'h0200);
    pushFrame(SYNC_A, 16'h0300);
    pushFrame(16'hFFFF, 16'h0400);
    pushFrame(16'hFFFF, 16'h0500);
    pushFrame(16'hFFFF, 16'h0600);
    pushFrame(SYNC_A, 16'h0700);
    buildBoth();
    runRange(0, streamQ.size(), 1'b0);
    checkInt("seg3 word count", wordsA.size(), 49);
    if (wordsA.size() > 7) checkWord("seg3 frame2 word1", wordsA[7], 16'h0201);
    checkInt("seg3 sync count", syncCount[0], 3);
    checkInt("seg3 lock falls", fallsA.size(), 0);

    // Four consecutive bad syncs drop lock, the next good frame relocks
    doReset();
    pushFrame(SYNC_A, 16'h0100);
    pushFrame(16'hFFFF, 16'h0100);
    pushFrame(16'hFFFF, 16'h0100);
    pushFrame(16'hFFFF, 16'h0100);
    pushFrame(16'hFFFF, 16'h0100);
    pushFrame(SYNC_A, 16'h0100);
    buildBoth();
    runRange(0, streamQ.size(), 1'b0);
    checkInt("seg4 word count", wordsA.size(), 35);
    checkInt("seg4 sync count", syncCount[0], 2);
    checkInt("seg4 lock falls", fallsA.size(), 1);
    if (fallsA.size() > 0) checkInt("seg4 fall bit", fallsA[0], 527);
    checkInt("seg4 lock rises", risesA.size(), 2);
    if (risesA.size() > 1) checkInt("seg4 relock bit", risesA[1], 655);
    if (seenAtA.size() > 28) checkInt("seg4 first word after relock", seenAtA[28], 671);

    // Random bit_valid gaps over three frames
    doReset();
    pushFrame(SYNC_A, 16'h0000);
    pushFrame(SYNC_A, 16'h0000);
    pushFrame(SYNC_A, 16'h0000);
    buildBoth();
    runRange(0, streamQ.size(), 1'b1);
    checkInt("seg5 word count", wordsA.size(), 21);
    for (int i = 0; i < wordsA.size() && i < 21; i++) begin
      checkWord($sformatf("seg5 word %0d", i), wordsA[i], 16'((i % 7) + 1));
    end
    checkInt("seg5 sync count", syncCount[0], 3);

    // Asynchronous reset in the middle of a payload word
    doReset();
    pushFrame(SYNC_A, 16'h0100);
    buildBoth();
    runRange(0, 56, 1'b0);
    checkBit("seg6 locked before rst", lockedO[0], 1'b1);
    checkWord("seg6 word before rst", wordO[0], 16'h0102);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkWord("async rst word_out", wordO[0], 16'h0000);
    checkBit("async rst locked", lockedO[0], 1'b0);
    checkBit("async rst locked dutB", lockedO[1], 1'b0);
    @(posedge clk);
    #1;
    checkOutput(1'b0);
    rst = 1'b0;
    clearLogs();
    streamQ.delete();
    pushWord(16'h0000);
    for (int i = 1; i < FW; i++) pushWord(16'h1111 * 16'(i));
    pushWord(16'h0000);
    for (int i = 1; i < FW; i++) pushWord(16'h1111 * 16'(i));
    buildBoth();
    runRange(0, 15, 1'b0);
    checkBit("seg6 dutB unlocked after 15 zero bits", lockedO[1], 1'b0);
    runRange(15, streamQ.size(), 1'b0);
    checkInt("seg6 dutB lock rises", risesB.size(), 1);
    if (risesB.size() > 0) checkInt("seg6 dutB lock bit", risesB[0], 15);
    checkInt("seg6 dutB word count", wordsB.size(), 14);
    for (int i = 0; i < wordsB.size() && i < 14; i++) begin
      checkWord($sformatf("seg6 dutB word %0d", i), wordsB[i], 16'h1111 * 16'((i % 7) + 1));
    end
    checkInt("seg6 dutB sync count", syncCount[1], 2);
    checkInt("seg6 dutA word count", wordsA.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
